outerprodrc_stream: RTL and testbench
=====================================

OUTERPRODRC_STREAM -- requirements
Module: outerprodrc_stream

Interface
REQ-001 SHALL have parameter ROWNUM, default 4, number of row-vector elements.
REQ-002 SHALL have parameter COLNUM, default 4, number of column-vector elements.
REQ-003 SHALL have parameter HIDDEN, default 8, number of row/col vector pairs accumulated per result.
REQ-004 SHALL have parameter CYCLE, default 256, unary bitstream length (beats) per vector pair; minimum 1.
REQ-005 SHALL have parameter ACCWIDTH, default 12, width of each output accumulator.
REQ-006 SHALL have port iClk, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port iRst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port iEn, input, 1, accept enable; beats not accepted while low.
REQ-009 SHALL have port iClr, input, 1, synchronous abort/clear.
REQ-010 SHALL have port iValid, input, 1, input beat valid.
REQ-011 SHALL have port oReady, output, 1, block accepts a beat this cycle.
REQ-012 SHALL have port iData0, input, ROWNUM, one unary bitstream bit per row element.
REQ-013 SHALL have port iData1, input, COLNUM, one unary bitstream bit per column element.
REQ-014 SHALL have port oValid, output, 1, result valid.
REQ-015 SHALL have port iReady, input, 1, downstream accepts result.
REQ-016 SHALL have port oData, output, ROWNUM*COLNUM*ACCWIDTH, element (i,j) at bits [(i*COLNUM+j)*ACCWIDTH +: ACCWIDTH].
REQ-017 SHALL have port oSat, output, 1, sticky saturation flag for the current result.

Function
REQ-018 SHALL implement FSM states IDLE, ACC, HOLD; beat accepted when iValid && oReady; oReady = iEn && state != HOLD.
REQ-019 SHALL, per accepted beat, compute product bit p(i,j) = iData0[i] & iData1[j] for every (i,j).
REQ-020 SHALL, on a beat accepted in IDLE, load acc(i,j) = p(i,j), set beat counter to 1, enter ACC (unless TOTAL = HIDDEN*CYCLE = 1, then enter HOLD).
REQ-021 SHALL, on a beat accepted in ACC, set acc(i,j) = acc(i,j) + p(i,j) and increment beat counter.
REQ-022 SHALL enter HOLD on the cycle after the TOTAL-th accepted beat; oValid = 1 exactly in HOLD.
REQ-023 SHALL hold oData and oSat stable in HOLD until iValid... oValid && iReady, then go IDLE (oData retains last value).
REQ-024 SHALL not accept a beat in HOLD even if iValid and iReady are both high that cycle.
REQ-025 SHALL on iClr (priority over beat and output handshake) zero all accumulators, beat counter and oSat, go IDLE; the coincident beat is dropped.
REQ-026 SHALL size the beat counter as clog2(TOTAL+1) bits; no wrap within a run.

Reset
REQ-027 SHALL on iRst asynchronously force state IDLE, accumulators, beat counter, oData, oValid, oSat to 0; oReady = iEn after reset.
REQ-028 SHALL abandon any in-progress run on reset; the next accepted beat starts a new run.

Configuration
REQ-029 SHALL provide macro OUTERPRODRC_STREAM_SAT_EN: defined -> an accumulator at 2^ACCWIDTH-1 holds on increment and sets oSat; undefined -> accumulators wrap modulo 2^ACCWIDTH and oSat is constant 0.

Verification (ROWNUM=COLNUM=2, HIDDEN=2, CYCLE=4, ACCWIDTH=12 unless stated)
REQ-030 SHALL check: 8 beats all-ones, iReady=1 -> every element 8, oValid high exactly one cycle after 8th beat.
REQ-031 SHALL check: 8 beats iData0=01, iData1=10 -> element (0,1)=8, others 0.
REQ-032 SHALL check: result with iReady low 5 cycles -> oData stable, oReady=0, iValid beats ignored, IDLE after iReady.
REQ-033 SHALL check: 3 ones beats, iClr, then 8 ones beats -> every element 8, not 11.
REQ-034 SHALL check: ACCWIDTH=3, 8 ones beats -> with SAT_EN 7 and oSat=1; without 0 and oSat=0.
REQ-035 SHALL check: iRst asserted mid-run after 5 beats -> all outputs 0 immediately; next 8 ones beats -> elements 8.

Source files
------------

// File: rtl/outerprodrc_stream_if.sv
// Beat/result handshake bundle for outerprodrc_stream; the slave modport faces the accumulator.
interface outerprodrc_stream_if #(
  parameter int ROWNUM   = 4,
  parameter int COLNUM   = 4,
  parameter int ACCWIDTH = 12
);
  logic                              iValid;
  logic                              oReady;
  logic [ROWNUM-1:0]                 iData0;
  logic [COLNUM-1:0]                 iData1;
  logic                              oValid;
  logic                              iReady;
  logic [ROWNUM*COLNUM*ACCWIDTH-1:0] oData;
  logic                              oSat;

  modport slave (
    input  iValid, iData0, iData1, iReady,
    output oReady, oValid, oData, oSat
  );

  modport master (
    output iValid, iData0, iData1, iReady,
    input  oReady, oValid, oData, oSat
  );
endinterface

// File: rtl/outerprodrc_stream.sv
// Unary-bitstream outer-product accumulator: HIDDEN*CYCLE beats of AND products per result.
// Optional saturation via macro OUTERPRODRC_STREAM_SAT_EN (undefined: accumulators wrap).
//
// state | meaning
// IDLE  | waiting for the first beat of a run
// ACC   | accumulating beats until TOTAL have been accepted
// HOLD  | result presented on oValid, waiting for iReady
module outerprodrc_stream #(
  parameter int ROWNUM   = 4,
  parameter int COLNUM   = 4,
  parameter int HIDDEN   = 8,
  parameter int CYCLE    = 256,
  parameter int ACCWIDTH = 12
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic                 iClr,
  outerprodrc_stream_if.slave  s
);
  localparam int TOTAL = HIDDEN * CYCLE;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int NEL   = ROWNUM * COLNUM;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic [NEL*ACCWIDTH-1:0] r_acc;
  logic                    r_sat;

  logic                    w_ready;
  logic                    w_beat;
  logic [NEL*ACCWIDTH-1:0] w_acc_nxt;
  logic                    w_sat_nxt;

  assign w_ready  = iEn && (r_state != HOLD);
  assign w_beat   = s.iValid && w_ready;
  assign s.oReady = w_ready;
  assign s.oValid = (r_state == HOLD);
  assign s.oData  = r_acc;
  assign s.oSat   = r_sat;

  always_comb begin
    w_acc_nxt = r_acc;
    w_sat_nxt = (r_state == IDLE) ? 1'b0 : r_sat;
    for (int i = 0; i < ROWNUM; i++) begin
      for (int j = 0; j < COLNUM; j++) begin
        logic                p;
        logic [ACCWIDTH-1:0] cur;
        p   = s.iData0[i] & s.iData1[j];
        cur = r_acc[(i*COLNUM+j)*ACCWIDTH +: ACCWIDTH];
        if (r_state == IDLE) begin
          w_acc_nxt[(i*COLNUM+j)*ACCWIDTH +: ACCWIDTH] = ACCWIDTH'(p);
        end else begin
`ifdef OUTERPRODRC_STREAM_SAT_EN
          if (p && (&cur)) begin
            w_sat_nxt = 1'b1;
          end else begin
            w_acc_nxt[(i*COLNUM+j)*ACCWIDTH +: ACCWIDTH] = cur + ACCWIDTH'(p);
          end
`else
          w_acc_nxt[(i*COLNUM+j)*ACCWIDTH +: ACCWIDTH] = cur + ACCWIDTH'(p);
`endif
        end
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else if (iClr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_beat) begin
            r_acc   <= w_acc_nxt;
            r_sat   <= w_sat_nxt;
            r_cnt   <= CW'(1);
            r_state <= (TOTAL == 1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (w_beat) begin
            r_acc <= w_acc_nxt;
            r_sat <= w_sat_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(TOTAL - 1)) begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          // result and counter frozen; no beat can be accepted here
          if (s.iReady) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_outerprodrc_stream.sv
// Directed bench for outerprodrc_stream (2x2, HIDDEN=2, CYCLE=4) plus an ACCWIDTH=3 copy for wrap/saturation.
module tb_outerprodrc_stream;
  localparam int RN = 2;
  localparam int CN = 2;
  localparam int HD = 2;
  localparam int CY = 4;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic iEn  = 1'b0;
  logic iClr = 1'b0;

  int checks = 0;
  int errors = 0;

  outerprodrc_stream_if #(.ROWNUM(RN), .COLNUM(CN), .ACCWIDTH(12)) m_if ();
  outerprodrc_stream_if #(.ROWNUM(RN), .COLNUM(CN), .ACCWIDTH(3))  n_if ();

  assign n_if.iValid = m_if.iValid;
  assign n_if.iData0 = m_if.iData0;
  assign n_if.iData1 = m_if.iData1;
  assign n_if.iReady = m_if.iReady;

  outerprodrc_stream #(.ROWNUM(RN), .COLNUM(CN), .HIDDEN(HD), .CYCLE(CY), .ACCWIDTH(12)) u_dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .s(m_if.slave)
  );

  outerprodrc_stream #(.ROWNUM(RN), .COLNUM(CN), .HIDDEN(HD), .CYCLE(CY), .ACCWIDTH(3)) u_narrow (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .s(n_if.slave)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic beats(input int n, input logic [RN-1:0] d0, input logic [CN-1:0] d1);
    m_if.iValid = 1'b1;
    m_if.iData0 = d0;
    m_if.iData1 = d1;
    for (int k = 0; k < n; k++) tick();
    m_if.iValid = 1'b0;
  endtask

  localparam logic [47:0] ALL8 = {12'd8, 12'd8, 12'd8, 12'd8};
  localparam logic [47:0] E01  = {12'd0, 12'd0, 12'd8, 12'd0};
`ifdef OUTERPRODRC_STREAM_SAT_EN
  localparam logic [11:0] NARROW_EXP = {3'd7, 3'd7, 3'd7, 3'd7};
  localparam logic        NARROW_SAT = 1'b1;
`else
  localparam logic [11:0] NARROW_EXP = 12'd0;
  localparam logic        NARROW_SAT = 1'b0;
`endif

  initial begin
    m_if.iValid = 1'b0;
    m_if.iData0 = '0;
    m_if.iData1 = '0;
    m_if.iReady = 1'b1;
    iEn  = 1'b1;
    iRst = 1'b1;
    #12;
    iRst = 1'b0;
    #3;
    check("reset_oData",  64'(m_if.oData), 64'd0);
    check("reset_oValid", 64'(m_if.oValid), 64'd0);
    check("reset_oSat",   64'(m_if.oSat), 64'd0);
    check("reset_oReady", 64'(m_if.oReady), 64'd1);
    iEn = 1'b0;
    #1;
    check("oReady_follows_iEn", 64'(m_if.oReady), 64'd0);
    iEn = 1'b1;
    tick();

    // all-ones run, iReady high
    beats(7, 2'b11, 2'b11);
    check("ones_no_valid_at_7", 64'(m_if.oValid), 64'd0);
    beats(1, 2'b11, 2'b11);
    check("ones_oValid",    64'(m_if.oValid), 64'd1);
    check("ones_oData",     64'(m_if.oData), 64'(ALL8));
    check("ones_oSat",      64'(m_if.oSat), 64'd0);
    check("narrow_oData",   64'(n_if.oData), 64'(NARROW_EXP));
    check("narrow_oSat",    64'(n_if.oSat), 64'(NARROW_SAT));
    tick();
    check("ones_valid_one_cycle", 64'(m_if.oValid), 64'd0);
    check("ones_retained",        64'(m_if.oData), 64'(ALL8));

    // single cross term
    beats(8, 2'b01, 2'b10);
    check("cross_oValid", 64'(m_if.oValid), 64'd1);
    check("cross_oData",  64'(m_if.oData), 64'(E01));
    tick();

    // back-pressure: beats offered during HOLD must be ignored
    m_if.iReady = 1'b0;
    beats(8, 2'b11, 2'b11);
    check("bp_hold_valid", 64'(m_if.oValid), 64'd1);
    m_if.iValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_oData_stable", 64'(m_if.oData), 64'(ALL8));
      check("bp_oReady_low",   64'(m_if.oReady), 64'd0);
      check("bp_oValid_high",  64'(m_if.oValid), 64'd1);
    end
    m_if.iValid = 1'b0;
    m_if.iReady = 1'b1;
    tick();
    check("bp_idle_valid", 64'(m_if.oValid), 64'd0);
    check("bp_idle_ready", 64'(m_if.oReady), 64'd1);

    // clear mid-run, coincident beat dropped
    beats(3, 2'b11, 2'b11);
    m_if.iValid = 1'b1;
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    m_if.iValid = 1'b0;
    check("clr_oData", 64'(m_if.oData), 64'd0);
    check("clr_oValid", 64'(m_if.oValid), 64'd0);
    beats(8, 2'b11, 2'b11);
    check("clr_run_oValid", 64'(m_if.oValid), 64'd1);
    check("clr_run_oData",  64'(m_if.oData), 64'(ALL8));
    tick();

    // asynchronous reset mid-run
    beats(5, 2'b11, 2'b11);
    #2;
    iRst = 1'b1;
    #1;
    check("rst_oData",  64'(m_if.oData), 64'd0);
    check("rst_oValid", 64'(m_if.oValid), 64'd0);
    check("rst_oSat",   64'(m_if.oSat), 64'd0);
    tick();
    iRst = 1'b0;
    beats(7, 2'b11, 2'b11);
    check("rst_run_no_valid_at_7", 64'(m_if.oValid), 64'd0);
    beats(1, 2'b11, 2'b11);
    check("rst_run_oValid", 64'(m_if.oValid), 64'd1);
    check("rst_run_oData",  64'(m_if.oData), 64'(ALL8));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
